// File: rtl/data_bus_responder_if.sv
// Data-side load/store bus between the core (master) and the data responder (slave).
// A request is held by the master until the one-cycle bus_ready pulse; bus_fault qualifies that pulse.
interface data_bus_responder_if;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [2:0]  bus_funct3;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        bus_fault;

    modport master (
        output bus_read, bus_write, bus_addr, bus_wdata, bus_funct3,
        input  bus_rdata, bus_ready, bus_fault
    );

    modport slave (
        input  bus_read, bus_write, bus_addr, bus_wdata, bus_funct3,
        output bus_rdata, bus_ready, bus_fault
    );
endinterface

// File: rtl/data_bus_responder.sv
// Word-organised data RAM behind a load/store bus with byte/half/word access,
// programmable wait states and fault reporting for malformed requests.
module data_bus_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_bus_responder_if.slave  bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LP_WS_LOAD = 4'(WAIT_STATES - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_funct3;
    logic        r_rd, r_wr, r_fault;
    logic [31:0] r_mem [2**ADDR_WIDTH];

    logic                  w_idle, w_req, w_capture, w_enter_resp;
    logic [31:0]           w_sel_addr, w_sel_wdata, w_word, w_load, w_wrep;
    logic [2:0]            w_sel_f3;
    logic                  w_sel_rd, w_sel_wr;
    logic                  w_f3_bad, w_misalign, w_range_bad, w_fault;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [3:0]            w_be;

    assign w_idle    = (r_state == S_IDLE);
    assign w_req     = bus.bus_read | bus.bus_write;
    assign w_capture = w_idle & w_req;

    // In IDLE the live inputs drive the datapath so a zero-wait access completes without a staging cycle.
    assign w_sel_addr  = w_idle ? bus.bus_addr   : r_addr;
    assign w_sel_wdata = w_idle ? bus.bus_wdata  : r_wdata;
    assign w_sel_f3    = w_idle ? bus.bus_funct3 : r_funct3;
    assign w_sel_rd    = w_idle ? bus.bus_read   : r_rd;
    assign w_sel_wr    = w_idle ? bus.bus_write  : r_wr;

    assign w_f3_bad    = w_sel_wr ? (w_sel_f3 > 3'd2)
                                  : ((w_sel_f3 == 3'd3) || (w_sel_f3 >= 3'd6));
    assign w_misalign  = ((w_sel_f3[1:0] == 2'b01) && w_sel_addr[0]) ||
                         ((w_sel_f3[1:0] == 2'b10) && (w_sel_addr[1:0] != 2'b00));
    assign w_range_bad = |w_sel_addr[31:ADDR_WIDTH+2];
    assign w_fault     = (w_sel_rd & w_sel_wr) | w_f3_bad | w_misalign | w_range_bad;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = LP_WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_next = S_RESP;
                else               w_cnt_next = r_cnt - 4'd1;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_addr   <= bus.bus_addr;
                r_wdata  <= bus.bus_wdata;
                r_funct3 <= bus.bus_funct3;
                r_rd     <= bus.bus_read;
                r_wr     <= bus.bus_write;
                r_fault  <= w_fault;
            end
        end
    end

    assign w_idx  = w_sel_addr[ADDR_WIDTH+1:2];
    assign w_word = r_mem[w_idx];
    assign w_half = w_sel_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_sel_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        w_load = 32'd0;
        case (w_sel_f3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd2:    w_load = w_word;
            3'd4:    w_load = {24'd0, w_byte};
            3'd5:    w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        w_be   = 4'b1111;
        w_wrep = w_sel_wdata;
        case (w_sel_f3[1:0])
            2'b00: begin
                w_be   = 4'b0001 << w_sel_addr[1:0];
                w_wrep = {4{w_sel_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = 4'b0011 << w_sel_addr[1:0];
                w_wrep = {2{w_sel_wdata[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wrep = w_sel_wdata;
            end
        endcase
    end

    // RAM is left unreset; stores commit and load data is captured on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (w_enter_resp) begin
            if (w_sel_wr && !w_fault) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
                end
            end
            r_rdata <= (w_sel_rd && !w_fault) ? w_load : 32'd0;
        end
    end

    assign bus.bus_ready = (r_state == S_RESP);
    assign bus.bus_fault = bus.bus_ready & r_fault;
    assign bus.bus_rdata = bus.bus_ready ? r_rdata : 32'd0;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: vector table for access semantics plus
// hand-written reset and latency-sweep sequences on three wait-state configurations.
module tb_data_bus_responder;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] dbg1, dbg0, dbg15;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    data_bus_responder_if bus1 ();
    data_bus_responder_if bus0 ();
    data_bus_responder_if bus15 ();

    data_bus_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus1.slave), .o_dbg_state(dbg1)
    );
    data_bus_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave), .o_dbg_state(dbg0)
    );
    data_bus_responder #(.ADDR_WIDTH(10), .WAIT_STATES(15)) u_dut15 (
        .clk(clk), .rst(rst), .bus(bus15.slave), .o_dbg_state(dbg15)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic        chk_rdata;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic drive_idle();
        bus1.bus_read = 0; bus1.bus_write = 0; bus1.bus_addr = 0; bus1.bus_wdata = 0; bus1.bus_funct3 = 0;
        bus0.bus_read = 0; bus0.bus_write = 0; bus0.bus_addr = 0; bus0.bus_wdata = 0; bus0.bus_funct3 = 0;
        bus15.bus_read = 0; bus15.bus_write = 0; bus15.bus_addr = 0; bus15.bus_wdata = 0; bus15.bus_funct3 = 0;
    endtask

    // Issue one request on the WAIT_STATES=1 instance and wait (bounded) for its ready pulse.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic fault, output int lat);
        bit seen = 0;
        rdata = 32'd0;
        fault = 1'b0;
        lat   = -1;
        @(negedge clk);
        bus1.bus_read = rd; bus1.bus_write = wr; bus1.bus_funct3 = f3;
        bus1.bus_addr = addr; bus1.bus_wdata = wdata;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus1.bus_ready) begin
                seen  = 1;
                lat   = k;
                rdata = bus1.bus_rdata;
                fault = bus1.bus_fault;
            end
        end
        bus1.bus_read = 0; bus1.bus_write = 0;
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          n_ready;
        int          n0, n15, err0, err15, flt0, flt15;

        //              rd  wr  f3    addr          wdata          exp_rdata      flt chk
        vecs[0]  = '{1'b0, 1'b1, 3'd2, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'd2, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 3'd2, 32'h20,       32'h80FF7F01, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'd0, 32'h23,       32'h0,        32'hFFFFFF80, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 3'd4, 32'h23,       32'h0,        32'h00000080, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 3'd1, 32'h20,       32'h0,        32'h00007F01, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 3'd5, 32'h22,       32'h0,        32'h000080FF, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 3'd1, 32'h22,       32'h0,        32'hFFFF80FF, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 3'd0, 32'h21,       32'h0,        32'h0000007F, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 3'd2, 32'h30,       32'h00000000, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'd0, 32'h31,       32'h000000AB, 32'h0,        1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'd1, 32'h32,       32'h00001234, 32'h0,        1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'd2, 32'h30,       32'h0,        32'h1234AB00, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 3'd2, 32'h02,       32'h0,        32'h0,        1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 3'd2, 32'h04,       32'h55667788, 32'h0,        1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 3'd1, 32'h05,       32'h0000FFFF, 32'h0,        1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 3'd2, 32'h04,       32'h0,        32'h55667788, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 3'd2, 32'h00001000, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 3'd2, 32'h10,       32'h11223344, 32'h0,        1'b1, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 3'd3, 32'h10,       32'h0,        32'h0,        1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 3'd4, 32'h10,       32'hCAFEF00D, 32'h0,        1'b1, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 3'd2, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 1'b1};

        drive_idle();
        rst = 1'b1;
        #7;
        check("reset_ready", {31'd0, bus1.bus_ready}, 32'd0);
        check("reset_fault", {31'd0, bus1.bus_fault}, 32'd0);
        check("reset_rdata", bus1.bus_rdata, 32'd0);
        check("reset_state", {30'd0, dbg1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rdata, fault, lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd2);
            check($sformatf("vec%0d_fault", i), {31'd0, fault}, {31'd0, vecs[i].exp_fault});
            if (vecs[i].chk_rdata) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Asynchronous reset in the middle of a RESP cycle truncates the pulse.
        @(negedge clk);
        bus1.bus_read = 1; bus1.bus_funct3 = 3'd2; bus1.bus_addr = 32'h10;
        n_ready = 0;
        for (int k = 0; k < 10 && n_ready == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus1.bus_ready) n_ready++;
        end
        check("resp_reached", n_ready, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ready", {31'd0, bus1.bus_ready}, 32'd0);
        check("async_rst_rdata", bus1.bus_rdata, 32'd0);
        check("async_rst_fault", {31'd0, bus1.bus_fault}, 32'd0);
        bus1.bus_read = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);

        // Reset while a store waits: no ready, RAM keeps the old word.
        @(negedge clk);
        bus1.bus_write = 1; bus1.bus_funct3 = 3'd2; bus1.bus_addr = 32'h10; bus1.bus_wdata = 32'h11111111;
        @(posedge clk);
        #1;
        check("store_in_wait", {30'd0, dbg1}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_wait_state", {30'd0, dbg1}, 32'd0);
        bus1.bus_write = 0;
        @(negedge clk);
        rst = 1'b0;
        n_ready = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (bus1.bus_ready) n_ready++;
        end
        check("rst_wait_no_ready", n_ready, 32'd0);
        access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, rdata, fault, lat);
        check("rst_wait_old_data", rdata, 32'hDEADBEEF);
        check("rst_wait_old_fault", {31'd0, fault}, 32'd0);

        // Latency sweep: LW held high on the zero- and fifteen-wait instances.
        n0 = 0; n15 = 0; err0 = 0; err15 = 0; flt0 = 0; flt15 = 0;
        @(negedge clk);
        bus0.bus_read = 1; bus0.bus_funct3 = 3'd2; bus0.bus_addr = 32'h0;
        bus15.bus_read = 1; bus15.bus_funct3 = 3'd2; bus15.bus_addr = 32'h0;
        for (int cyc = 1; cyc <= 340; cyc++) begin
            @(posedge clk);
            #1;
            if (bus0.bus_ready && cyc <= 40) begin
                if (cyc != 1 + n0 * 2) err0++;
                if (bus0.bus_fault) flt0++;
                n0++;
            end
            if (bus15.bus_ready) begin
                if (cyc != 16 + n15 * 17) err15++;
                if (bus15.bus_fault) flt15++;
                n15++;
            end
        end
        drive_idle();
        check("ws0_count", n0, 32'd20);
        check("ws0_spacing", err0, 32'd0);
        check("ws0_fault", flt0, 32'd0);
        check("ws15_count", n15, 32'd20);
        check("ws15_spacing", err15, 32'd0);
        check("ws15_fault", flt15, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Data-side bus responder for the single-cycle RISC-V core: it serves the load/store requests that the control decoder raises on `bus_read`/`bus_write`. It holds a word-organised data RAM, performs byte/half/word accesses with sign or zero extension, inserts a programmable number of wait states, and signals completion with a one-cycle `bus_ready` pulse that the core uses to stall. Misaligned, out-of-range and malformed requests complete with `bus_fault` and have no side effects.

## Interface
- `ADDR_WIDTH`, 10: word-address width; RAM depth is 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 1: extra cycles between request capture and `bus_ready`; legal range 0..15.

- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `bus_read` input 1: load request; held by the core until `bus_ready`.
- `bus_write` input 1: store request; held by the core until `bus_ready`.
- `bus_addr` input 32: byte address (ALU result).
- `bus_wdata` input 32: store data (rs2), right-aligned.
- `bus_funct3` input 3: access size/sign; loads 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU; stores 0=SB, 1=SH, 2=SW.
- `bus_rdata` output 32: extended load data; valid only while `bus_ready`=1.
- `bus_ready` output 1: one-cycle completion pulse.
- `bus_fault` output 1: qualifies `bus_ready`; request rejected.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: if `bus_read` or `bus_write` is high, the responder latches addr, wdata, funct3 and the direction, then moves to WAIT, or to RESP when `WAIT_STATES`=0. Otherwise it stays in IDLE.
- WAIT: a 4-bit counter loads `WAIT_STATES`-1 on entry and decrements. The FSM moves to RESP when the counter reaches 0.
- RESP: `bus_ready`=1 for exactly this cycle, then the FSM returns to IDLE unconditionally. A request still high in that IDLE cycle is treated as a new request.
- A fault is computed at capture and applies when any of these hold:
  - `bus_read` and `bus_write` are both high;
  - funct3 is illegal for the direction (loads 3/6/7, stores 3..7);
  - LH/LHU/SH with addr[0]≠0;
  - LW/SW with addr[1:0]≠0;
  - addr[31:ADDR_WIDTH+2] ≠ 0.
- Faulted request: no RAM write, `bus_rdata`=0, `bus_fault`=1 with `bus_ready`.
- Load: the RAM word at addr[ADDR_WIDTH+1:2] is read. The lane is selected by addr[1:0]:
  - byte = word[8*addr[1:0]+7 -: 8];
  - half = word[16*addr[1]+15 -: 16];
  - LB/LH sign-extend, LBU/LHU zero-extend.
- Store: byte-enable mask is
  - SB: 4'b0001<<addr[1:0];
  - SH: 4'b0011<<addr[1:0];
  - SW: 4'b1111.
  The byte/half is replicated across lanes, and only the enabled bytes are written.
- RAM contents are not reset; only control state is reset.

## Timing
- Reset values: `bus_ready`=0, `bus_fault`=0, `bus_rdata`=0, FSM=IDLE, counter=0.
- Request first high in cycle T while in IDLE: capture at the end of T, and `bus_ready` is high in cycle T+1+`WAIT_STATES`. Latency is `WAIT_STATES`+1 cycles; throughput is one access per `WAIT_STATES`+2 cycles.
- A store commits at the rising edge that enters RESP, so a load issued in the following IDLE cycle returns the new data.
- Request inputs are ignored outside IDLE; changes during WAIT/RESP have no effect.
- `rst` asserted during WAIT: the FSM returns to IDLE immediately, the pending store is discarded, and no `bus_ready` is produced. RAM is unchanged.
- `rst` asserted during RESP: the pulse is truncated and all outputs go to 0 asynchronously.

## Test plan
- **Reset:** assert `rst` mid-cycle → outputs 0 without a clock edge. Then SW with WAIT_STATES=1 is issued and `rst` is pulsed in WAIT → no ready; LW of the same address later returns the old value.
- **Word round trip:** SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rdata 0xDEADBEEF, fault 0. `bus_ready` is seen exactly 2 cycles after each request appears (WAIT_STATES=1).
- **Byte/half extension:** SW 0x20 0x80FF7F01, then:
  - LB 0x23 → 0xFFFFFF80;
  - LBU 0x23 → 0x00000080;
  - LH 0x20 → 0x00007F01;
  - LHU 0x22 → 0x000080FF.
- **Partial stores:** SW 0x30 0x00000000, SB 0x31 0xAB, SH 0x32 0x1234, LW 0x30 → 0x1234AB00.
- **Faults:**
  - LW 0x02 → ready+fault, rdata 0;
  - SH 0x05 → fault, and a later LW 0x04 is unchanged;
  - addr 0x00001000 with ADDR_WIDTH=10 → fault;
  - read+write both high → fault;
  - load funct3=3 → fault.
- **Latency sweep:** WAIT_STATES=0 gives ready at T+1, and WAIT_STATES=15 gives ready at T+16. For both, 20 back-to-back LW requests with the request held high complete one per `WAIT_STATES`+2 cycles.
